// File: rtl/poly_music_player.sv
// Tempo-stepped song index driving NUM_CH square-wave voices mixed into one PWM stream.
// Define FADE_OUT_EN to fade the volume over the last 4 beats of a non-looping song.
module poly_music_player #(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int BEAT_FREQ = 8,
   parameter int NUM_CH    = 2,
   parameter int SONG_LEN  = 128,
   parameter int HP_W      = 20,
   parameter int VOL_W     = 4,
   localparam int IB_W     = $clog2(SONG_LEN),
   localparam int PWM_W    = VOL_W + $clog2(NUM_CH + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   pause,
   input  logic                   stop,
   input  logic                   loop_en,
   input  logic [1:0]             tempo_sel,
   input  logic [NUM_CH*HP_W-1:0] ch_half,
   input  logic [NUM_CH-1:0]      ch_mute,
   input  logic [VOL_W-1:0]       volume,
   output logic [IB_W-1:0]        ibeat,
   output logic                   playing,
   output logic                   done,
   output logic                   pmod_1,
   output logic                   pmod_2,
   output logic                   pmod_4
);

   localparam int BEAT_DIV = CLK_FREQ / BEAT_FREQ;
   localparam int BC_W     = $clog2(2 * BEAT_DIV);
   localparam int AC_W     = $clog2(NUM_CH + 1);
   localparam logic [IB_W-1:0] LAST = IB_W'(SONG_LEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE, S_DONE} state_e;

   state_e                   state_q, state_d;
   logic [BC_W-1:0]          bcnt_q, bcnt_d;
   logic [1:0]               tempo_q, tempo_d;
   logic [IB_W-1:0]          ibeat_q, ibeat_d;
   logic                     done_q, done_d;
   logic                     playing_q, playing_d;
   logic                     ld_q, ld_d;
   logic [NUM_CH-1:0][HP_W-1:0] half_q, half_d;
   logic [NUM_CH-1:0][HP_W-1:0] cnt_q, cnt_d;
   logic [NUM_CH-1:0]        ph_q, ph_d;
   logic [PWM_W-1:0]         ramp_q, ramp_d;
   logic                     pwm_q, pwm_d;
   logic                     run, tick;
   logic [AC_W-1:0]          active;
   logic [VOL_W-1:0]         vol_eff;
   logic [PWM_W-1:0]         level;

   function automatic logic [BC_W-1:0] beat_last(input logic [1:0] t);
      case (t)
         2'd1:    return BC_W'(BEAT_DIV / 2 - 1);
         2'd2:    return BC_W'(2 * BEAT_DIV - 1);
         default: return BC_W'(BEAT_DIV - 1);
      endcase
   endfunction

   // Commands win over the beat tick; counters only advance on a clean PLAY cycle.
   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      tempo_d = tempo_q;
      ibeat_d = ibeat_q;
      done_d  = 1'b0;
      ld_d    = 1'b0;
      run     = 1'b0;
      tick    = (bcnt_q == beat_last(tempo_q));
      if (stop) begin
         state_d = S_IDLE;
         ibeat_d = '0;
         bcnt_d  = '0;
      end else if (pause) begin
         if (state_q == S_PLAY) state_d = S_PAUSE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: if (start) begin
               state_d = S_PLAY;
               ibeat_d = '0;
               bcnt_d  = '0;
               tempo_d = tempo_sel;
               ld_d    = 1'b1;
            end
            S_PAUSE: if (start) begin
               state_d = S_PLAY;
               ld_d    = 1'b1;
            end
            S_PLAY: begin
               run = 1'b1;
               if (tick) begin
                  bcnt_d  = '0;
                  tempo_d = tempo_sel;
                  if (ibeat_q != LAST) begin
                     ibeat_d = ibeat_q + IB_W'(1);
                     ld_d    = 1'b1;
                  end else if (loop_en) begin
                     ibeat_d = '0;
                     ld_d    = 1'b1;
                  end else begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                  end
               end else begin
                  bcnt_d = bcnt_q + BC_W'(1);
               end
            end
            default: ;
         endcase
      end
      playing_d = (state_d == S_PLAY);
   end

   always_comb begin
      half_d = half_q;
      cnt_d  = cnt_q;
      ph_d   = ph_q;
      for (int c = 0; c < NUM_CH; c++) begin
         if (run) begin
            if (ld_q && ch_half[c*HP_W +: HP_W] != half_q[c]) begin
               half_d[c] = ch_half[c*HP_W +: HP_W];
               cnt_d[c]  = '0;
               ph_d[c]   = 1'b0;
            end else if (half_q[c] == '0) begin
               cnt_d[c] = '0;
               ph_d[c]  = 1'b0;
            end else if (cnt_q[c] == half_q[c] - HP_W'(1)) begin
               cnt_d[c] = '0;
               ph_d[c]  = ~ph_q[c];
            end else begin
               cnt_d[c] = cnt_q[c] + HP_W'(1);
            end
         end
      end
   end

`ifdef FADE_OUT_EN
   localparam logic [IB_W-1:0] FADE_START = IB_W'(SONG_LEN - 4);
   localparam logic [IB_W:0]   FADE_BASE  = (IB_W+1)'(SONG_LEN - 5);
   logic [IB_W:0] fade_sh;
`endif

   always_comb begin
      vol_eff = volume;
`ifdef FADE_OUT_EN
      fade_sh = '0;
      if (!loop_en && ibeat_q >= FADE_START) begin
         fade_sh = {1'b0, ibeat_q} - FADE_BASE;
         vol_eff = volume >> fade_sh;
      end
`endif
      active = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (ph_q[c] && !ch_mute[c] && half_q[c] != '0) active = active + AC_W'(1);
      end
      level  = (state_q == S_PLAY) ? PWM_W'(active) * PWM_W'(vol_eff) : '0;
      ramp_d = ramp_q + PWM_W'(1);
      pwm_d  = (ramp_q < level);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         bcnt_q    <= '0;
         tempo_q   <= '0;
         ibeat_q   <= '0;
         done_q    <= 1'b0;
         playing_q <= 1'b0;
         ld_q      <= 1'b0;
         half_q    <= '0;
         cnt_q     <= '0;
         ph_q      <= '0;
         ramp_q    <= '0;
         pwm_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bcnt_q    <= bcnt_d;
         tempo_q   <= tempo_d;
         ibeat_q   <= ibeat_d;
         done_q    <= done_d;
         playing_q <= playing_d;
         ld_q      <= ld_d;
         half_q    <= half_d;
         cnt_q     <= cnt_d;
         ph_q      <= ph_d;
         ramp_q    <= ramp_d;
         pwm_q     <= pwm_d;
      end
   end

   assign ibeat   = ibeat_q;
   assign playing = playing_q;
   assign done    = done_q;
   assign pmod_1  = pwm_q;
   assign pmod_2  = 1'b1;
   assign pmod_4  = 1'b1;

endmodule

// File: tb/tb_poly_music_player.sv
// Bench for poly_music_player: directed transport/tempo steps plus randomized songs
// against a time-based behavioural model of beats, notes and the PWM mix.
module tb_poly_music_player;

   localparam int CLK_FREQ = 1600;
   localparam int BEAT_FREQ = 8;
   localparam int NUM_CH = 2;
   localparam int SONG_LEN = 8;
   localparam int HP_W = 20;
   localparam int VOL_W = 4;
   localparam int RAMP = 64;

   logic clk, reset, start, pause, stop, loop_en;
   logic [1:0] tempo_sel;
   logic [NUM_CH*HP_W-1:0] ch_half;
   logic [NUM_CH-1:0] ch_mute;
   logic [VOL_W-1:0] volume;
   logic [2:0] ibeat;
   logic playing, done, pmod_1, pmod_2, pmod_4;

   poly_music_player #(
      .CLK_FREQ(CLK_FREQ), .BEAT_FREQ(BEAT_FREQ), .NUM_CH(NUM_CH),
      .SONG_LEN(SONG_LEN), .HP_W(HP_W), .VOL_W(VOL_W)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .pause(pause), .stop(stop),
      .loop_en(loop_en), .tempo_sel(tempo_sel), .ch_half(ch_half),
      .ch_mute(ch_mute), .volume(volume), .ibeat(ibeat), .playing(playing),
      .done(done), .pmod_1(pmod_1), .pmod_2(pmod_2), .pmod_4(pmod_4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2, M_DONE = 3;

   int checks = 0;
   int errors = 0;
   int m_state, m_beat, m_elapsed, m_len, m_cyc;
   bit m_ld, m_done, m_pmod;
   int m_half [NUM_CH];
   int m_age [NUM_CH];
   int note_tab [SONG_LEN][NUM_CH];
   int hi_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int period(input int t);
      if (t == 1) return 100;
      if (t == 2) return 400;
      return 200;
   endfunction

   task automatic model_reset();
      m_state = M_IDLE; m_beat = 0; m_elapsed = 0; m_len = 200;
      m_cyc = 0; m_ld = 0; m_done = 0; m_pmod = 0;
      for (int c = 0; c < NUM_CH; c++) begin m_half[c] = 0; m_age[c] = 0; end
   endtask

   // One clock edge of the reference: beat time as elapsed play cycles,
   // each voice's phase as floor(age/half) mod 2.
   task automatic model_edge();
      int active, vol, level, nh;
      bit run;
      active = 0;
      for (int c = 0; c < NUM_CH; c++)
         if (!ch_mute[c] && m_half[c] != 0 && ((m_age[c] / m_half[c]) % 2) == 1) active++;
      vol = int'(volume);
`ifdef FADE_OUT_EN
      if (!loop_en && m_beat >= SONG_LEN - 4) vol = vol >> (m_beat - (SONG_LEN - 4) + 1);
`endif
      level = (m_state == M_PLAY) ? active * vol : 0;
      m_pmod = (m_cyc % RAMP) < level;
      m_cyc++;
      m_done = 0;
      run = (m_state == M_PLAY) && !stop && !pause;
      if (run) begin
         for (int c = 0; c < NUM_CH; c++) begin
            nh = int'(ch_half[c*HP_W +: HP_W]);
            if (m_ld && nh != m_half[c]) begin m_half[c] = nh; m_age[c] = 0; end
            else m_age[c]++;
         end
         m_ld = 0;
         m_elapsed++;
         if (m_elapsed == m_len) begin
            m_elapsed = 0;
            m_len = period(int'(tempo_sel));
            if (m_beat < SONG_LEN - 1) begin m_beat++; m_ld = 1; end
            else if (loop_en) begin m_beat = 0; m_ld = 1; end
            else begin m_state = M_DONE; m_done = 1; end
         end
      end else begin
         m_ld = 0;
         if (stop) begin m_state = M_IDLE; m_beat = 0; m_elapsed = 0; end
         else if (pause) begin if (m_state == M_PLAY) m_state = M_PAUSE; end
         else if (start) begin
            if (m_state == M_IDLE || m_state == M_DONE) begin
               m_state = M_PLAY; m_beat = 0; m_elapsed = 0;
               m_len = period(int'(tempo_sel)); m_ld = 1;
            end else if (m_state == M_PAUSE) begin
               m_state = M_PLAY; m_ld = 1;
            end
         end
      end
   endtask

   task automatic drive_notes();
      for (int c = 0; c < NUM_CH; c++) ch_half[c*HP_W +: HP_W] = HP_W'(note_tab[m_beat][c]);
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      chk("ibeat", 32'(ibeat), 32'(m_beat));
      chk("playing", 32'(playing), 32'(m_state == M_PLAY));
      chk("done", 32'(done), 32'(m_done));
      chk("pmod_1", 32'(pmod_1), 32'(m_pmod));
      if (pmod_1) hi_cnt++;
      drive_notes();
   endtask

   task automatic fill_table();
      for (int b = 0; b < SONG_LEN; b++)
         for (int c = 0; c < NUM_CH; c++)
            if (b > 0 && $urandom_range(0, 1) == 1) note_tab[b][c] = note_tab[b-1][c];
            else if ($urandom_range(0, 4) == 0) note_tab[b][c] = 0;
            else note_tab[b][c] = int'($urandom_range(1, 12));
   endtask

   initial begin
      reset = 1'b0; start = 0; pause = 0; stop = 0; loop_en = 0;
      tempo_sel = 2'd0; ch_half = '0; ch_mute = '0; volume = '0;
      hi_cnt = 0;
      model_reset();
      #12;
      chk("rst_ibeat", 32'(ibeat), 0);
      chk("rst_playing", 32'(playing), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_pmod1", 32'(pmod_1), 0);
      chk("pmod_2", 32'(pmod_2), 1);
      chk("pmod_4", 32'(pmod_4), 1);

      for (int b = 0; b < SONG_LEN; b++) begin note_tab[b][0] = 5; note_tab[b][1] = 0; end
      note_tab[3][0] = 7;
      note_tab[4][1] = 3;
      drive_notes();
      volume = 4'd15;
      @(negedge clk) reset = 1'b1;

      start = 1; step(); start = 0;
      repeat (199) step();
      chk("x1_pre", 32'(ibeat), 0);
      chk("tone_active", 32'(hi_cnt > 0), 1);
      step();
      chk("x1_beat", 32'(ibeat), 1);
      repeat (50) step();
      tempo_sel = 2'd1;
      repeat (150) step();
      chk("midbeat_change", 32'(ibeat), 2);
      repeat (100) step();
      chk("x2_beat", 32'(ibeat), 3);
      tempo_sel = 2'd2;
      repeat (100) step();
      chk("x2_again", 32'(ibeat), 4);
      repeat (399) step();
      chk("x05_pre", 32'(ibeat), 4);
      step();
      chk("x05_beat", 32'(ibeat), 5);
      tempo_sel = 2'd0;

      repeat (150) step();
      pause = 1; step();
      repeat (99) step();
      chk("pause_play", 32'(playing), 0);
      chk("pause_beat", 32'(ibeat), 5);
      chk("pause_silent", 32'(pmod_1), 0);
      pause = 0; start = 1; step(); start = 0;
      repeat (249) step();
      chk("resume_pre", 32'(ibeat), 5);
      step();
      chk("resume_beat", 32'(ibeat), 6);

      repeat (200) step();
      repeat (199) step();
      chk("last_beat", 32'(ibeat), 7);
      chk("no_early_done", 32'(done), 0);
      step();
      chk("done_pulse", 32'(done), 1);
      chk("done_play", 32'(playing), 0);
      chk("done_beat", 32'(ibeat), 7);
      step();
      chk("done_once", 32'(done), 0);
      chk("done_silent", 32'(pmod_1), 0);

      loop_en = 1;
      start = 1; step(); start = 0;
      chk("restart_beat", 32'(ibeat), 0);
      repeat (1599) step();
      chk("loop_pre", 32'(ibeat), 7);
      step();
      chk("loop_wrap", 32'(ibeat), 0);
      chk("loop_nodone", 32'(done), 0);
      chk("loop_play", 32'(playing), 1);

      repeat (200) step();
      pause = 1; start = 1; step(); start = 0;
      chk("pause_start", 32'(playing), 0);
      chk("pause_start_beat", 32'(ibeat), 1);
      stop = 1; step(); stop = 0; pause = 0;
      chk("stop_pause_beat", 32'(ibeat), 0);
      chk("stop_pause_play", 32'(playing), 0);

      start = 1; step(); start = 0;
      repeat (300) step();
      chk("pre_reset_beat", 32'(ibeat), 1);
      #2 reset = 1'b0;
      #1;
      chk("async_ibeat", 32'(ibeat), 0);
      chk("async_playing", 32'(playing), 0);
      chk("async_done", 32'(done), 0);
      chk("async_pmod1", 32'(pmod_1), 0);
      model_reset();
      @(negedge clk) reset = 1'b1;

      for (int n = 0; n < 20000; n++) begin
         if (n % 3000 == 0) fill_table();
         if (n % 500 == 0) begin
            volume = VOL_W'($urandom_range(0, 15));
            ch_mute = NUM_CH'($urandom_range(0, 3));
            tempo_sel = 2'($urandom_range(0, 3));
            loop_en = 1'($urandom_range(0, 1));
         end
         start = ($urandom_range(0, 79) == 0);
         stop = ($urandom_range(0, 1499) == 0);
         if ($urandom_range(0, 399) == 0) pause = ~pause;
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
